ntt_pair_addr_gen: RTL and testbench

- Parametrised successor to the single-mode NTT address sequencer.
- Emits one radix-2 butterfly per handshake for a full N-point transform, N = 2^LOG_N: both operand addresses, the twiddle-ROM address and the stage index.
- Supports forward (Cooley-Tukey, span halving) and inverse (Gentleman-Sande, span doubling) ordering.
- Supports downstream back-pressure, a programmable inter-stage drain gap, and start/done control.
- Sits between the NTT controller and the coefficient RAM / twiddle ROM.

---
 rtl/ntt_pair_addr_gen.sv | 131 +++++++++++++
 tb/tb_ntt_pair_addr_gen.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/ntt_pair_addr_gen.sv
// Radix-2 NTT butterfly address sequencer: one (addr_a, addr_b, twiddle, stage) per handshake,
// forward (span halving) or inverse (span doubling), with back-pressure and optional inter-stage drain gap.
module ntt_pair_addr_gen #(
  parameter int LOG_N     = 8,
  parameter int STAGE_GAP = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      inverse,
  input  logic                      out_ready,
  output logic                      out_valid,
  output logic [LOG_N-1:0]          addr_a,
  output logic [LOG_N-1:0]          addr_b,
  output logic [LOG_N-2:0]          tw_addr,
  output logic [$clog2(LOG_N)-1:0]  stage,
  output logic                      last_in_stage,
  output logic                      busy,
  output logic                      done
);

  localparam int KW  = LOG_N - 1;
  localparam int SW  = $clog2(LOG_N);
  localparam int SHW = SW + 1;
  localparam logic [KW-1:0] LAST_K   = '1;
  localparam logic [SW-1:0] LAST_S   = SW'(LOG_N - 1);
  localparam logic [3:0]    GAP_LOAD = (STAGE_GAP > 0) ? 4'(STAGE_GAP - 1) : 4'd0;

  typedef enum logic [1:0] {IDLE, RUN, GAP, FIN} state_t;

  state_t          state, stateNext;
  logic [KW-1:0]   k, kNext;
  logic [SW-1:0]   s, sNext;
  logic            inv, invNext;
  logic [3:0]      gapCnt, gapNext;
  logic            accept;

  logic [SHW-1:0]   shN, twShN;
  logic [LOG_N-1:0] halfN, jN, aN;
  logic [KW-1:0]    twN;
  logic             validN;

  assign accept = out_valid & out_ready;

  // Outputs are registered from the next-state counters so they are stable for the whole cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state         <= IDLE;
      k             <= '0;
      s             <= '0;
      inv           <= 1'b0;
      gapCnt        <= '0;
      out_valid     <= 1'b0;
      addr_a        <= '0;
      addr_b        <= '0;
      tw_addr       <= '0;
      stage         <= '0;
      last_in_stage <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
    end else begin
      state         <= stateNext;
      k             <= kNext;
      s             <= sNext;
      inv           <= invNext;
      gapCnt        <= gapNext;
      out_valid     <= validN;
      addr_a        <= validN ? aN : '0;
      addr_b        <= validN ? (aN | halfN) : '0;
      tw_addr       <= validN ? twN : '0;
      stage         <= validN ? sNext : '0;
      last_in_stage <= validN && (kNext == LAST_K);
      busy          <= (stateNext != IDLE);
      done          <= (stateNext == FIN);
    end
  end

  always_comb begin
    stateNext = state;
    kNext     = k;
    sNext     = s;
    invNext   = inv;
    gapNext   = gapCnt;
    unique case (state)
      IDLE: begin
        if (start) begin
          stateNext = RUN;
          kNext     = '0;
          sNext     = '0;
          invNext   = inverse;
        end
      end
      RUN: begin
        if (accept) begin
          if (k == LAST_K) begin
            kNext = '0;
            if (s == LAST_S) begin
              stateNext = FIN;
            end else begin
              sNext = s + 1'b1;
              if (STAGE_GAP > 0) begin
                stateNext = GAP;
                gapNext   = GAP_LOAD;
              end
            end
          end else begin
            kNext = k + 1'b1;
          end
        end
      end
      GAP: begin
        if (gapCnt == '0) stateNext = RUN;
        else              gapNext   = gapCnt - 1'b1;
      end
      FIN:     stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // Butterfly k of a stage: group index above bit sh, offset j below; twiddle stride scales with span.
  always_comb begin
    shN    = invNext ? SHW'(sNext) : (SHW'(LAST_S) - SHW'(sNext));
    twShN  = SHW'(LAST_S) - shN;
    halfN  = LOG_N'(1) << shN;
    jN     = LOG_N'(kNext) & (halfN - 1'b1);
    aN     = ((LOG_N'(kNext) >> shN) << (shN + 1'b1)) | jN;
    twN    = KW'(jN << twShN);
    validN = (stateNext == RUN);
  end

endmodule

// File: tb/tb_ntt_pair_addr_gen.sv
// Scoreboard bench for ntt_pair_addr_gen: two instances (drain gap 0 and 2) share start/mode/reset stimulus.
module tb_ntt_pair_addr_gen;

  localparam int LN  = 3;
  localparam int NN  = 1 << LN;
  localparam int HB  = NN / 2;
  localparam int SWT = $clog2(LN);

  logic       clk = 1'b0;
  logic       rst, start, inverse, readyAll, randReady, endCheck;
  logic [1:0] rndBits;
  int         tests = 0;
  int         fails = 0;

  always #5 clk = ~clk;

  typedef struct {int a; int b; int tw; int st; int last;} bf_t;

  task automatic check(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : gen_i
    localparam int GP = 2 * g;

    logic             rdy, outValid, lastIn, busyO, doneO;
    logic [LN-1:0]    aO, bO;
    logic [LN-2:0]    twO;
    logic [SWT-1:0]   stO;

    assign rdy = randReady ? rndBits[g] : readyAll;

    ntt_pair_addr_gen #(.LOG_N(LN), .STAGE_GAP(GP)) dut (
      .clk(clk), .rst(rst), .start(start), .inverse(inverse), .out_ready(rdy),
      .out_valid(outValid), .addr_a(aO), .addr_b(bO), .tw_addr(twO), .stage(stO),
      .last_in_stage(lastIn), .busy(busyO), .done(doneO)
    );

    bf_t q[$];
    int  mode = 0;       // 0 idle, 1 running, 2 done cycle
    int  cur, gapRem = 0, busyCnt = 0, stallCnt = 0;
    bit  chkZero = 0, endDone = 0;
    bf_t e;

    task automatic ck(input string nm, input int act, input int exp);
      check($sformatf("gap%0d %s", GP, nm), act, exp);
    endtask

    // Reference order: per stage, groups of 2*span points, each paired with its partner span away.
    function automatic void fill(input bit invMode);
      for (int s = 0; s < LN; s++) begin
        int sh;
        int span;
        sh   = invMode ? s : LN - 1 - s;
        span = 1 << sh;
        for (int grp = 0; grp < NN / (2 * span); grp++) begin
          for (int j = 0; j < span; j++) begin
            bf_t b;
            b.a    = grp * 2 * span + j;
            b.b    = b.a + span;
            b.tw   = j * (HB / span);
            b.st   = s;
            b.last = (grp * span + j == HB - 1) ? 1 : 0;
            q.push_back(b);
          end
        end
      end
    endfunction

    always @(negedge clk) begin
      cur = mode;
      if (chkZero) begin
        ck("rst valid", outValid, 0);
        ck("rst addr_a", aO, 0);
        ck("rst addr_b", bO, 0);
        ck("rst tw", twO, 0);
        ck("rst stage", stO, 0);
        ck("rst last", lastIn, 0);
        ck("rst busy", busyO, 0);
        ck("rst done", doneO, 0);
        chkZero = 0;
      end
      case (cur)
        0: begin
          ck("idle valid", outValid, 0);
          ck("idle busy", busyO, 0);
          ck("idle done", doneO, 0);
        end
        1: begin
          busyCnt++;
          ck("run busy", busyO, 1);
          ck("run done", doneO, 0);
          if (gapRem > 0) begin
            ck("gap valid", outValid, 0);
            gapRem--;
          end else begin
            ck("run valid", outValid, 1);
            if (outValid && q.size() > 0) begin
              e = q[0];
              ck("addr_a", aO, e.a);
              ck("addr_b", bO, e.b);
              ck("tw_addr", twO, e.tw);
              ck("stage", stO, e.st);
              ck("last_in_stage", lastIn, e.last);
              if (rdy) begin
                void'(q.pop_front());
                if (q.size() == 0) mode = 2;
                else if (e.last != 0) gapRem = GP;
              end else begin
                stallCnt++;
              end
            end
          end
        end
        default: begin
          busyCnt++;
          ck("fin valid", outValid, 0);
          ck("fin done", doneO, 1);
          ck("fin busy", busyO, 1);
          ck("busy cycles", busyCnt, LN * HB + (LN - 1) * GP + stallCnt + 1);
          mode = 0;
        end
      endcase
      if (!rst) begin
        mode    = 0;
        q.delete();
        gapRem  = 0;
        chkZero = 1;
      end else if (cur == 0 && start) begin
        fill(inverse);
        mode     = 1;
        gapRem   = 0;
        busyCnt  = 0;
        stallCnt = 0;
      end
      if (endCheck && !endDone) begin
        ck("idle at end", mode, 0);
        ck("queue empty", q.size(), 0);
        endDone = 1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input bit inv);
    start   = 1'b1;
    inverse = inv;
    tick();
    start   = 1'b0;
    inverse = 1'($urandom);
  endtask

  initial begin
    rndBits = '1;
    forever begin
      @(posedge clk);
      #1;
      rndBits = {($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0)};
    end
  end

  initial begin
    rst = 1'b0; start = 1'b0; inverse = 1'b0;
    readyAll = 1'b1; randReady = 1'b0; endCheck = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    repeat (2) tick();

    launch(1'b0);                // forward, full throughput
    repeat (30) tick();
    launch(1'b1);                // inverse
    repeat (30) tick();

    launch(1'b0);                // hold butterfly (1,5,1) for 3 cycles
    tick();
    readyAll = 1'b0;
    repeat (3) tick();
    readyAll = 1'b1;
    repeat (30) tick();

    launch(1'b0);                // start while running is ignored
    repeat (4) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (30) tick();

    start = 1'b1;                // start held through the done cycle into the next idle cycle
    tick();
    start = 1'b0;
    repeat (12) tick();
    start = 1'b1;
    repeat (2) tick();
    start = 1'b0;
    repeat (40) tick();

    launch(1'b0);                // reset during stage 1
    repeat (6) tick();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    launch(1'b0);
    repeat (30) tick();

    randReady = 1'b1;
    for (int i = 0; i < 8; i++) begin
      launch(1'($urandom));
      repeat ($urandom_range(3, 10)) tick();
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (60) tick();
    end
    randReady = 1'b0;
    repeat (40) tick();

    endCheck = 1'b1;
    repeat (2) tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
